// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single RAM port to icache fill, dcache miss or write-queue drain.
// Optional starvation guard for instruction fetch is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dmissREN,
   input  logic [31:0] dmissaddr,
   output logic        dmisswait,
   output logic [31:0] dload,
   input  logic        dqueueWEN,
   input  logic [31:0] wdaddr,
   input  logic [31:0] dstore,
   input  logic        wempty,
   output logic        wqwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramwait
);
   typedef enum logic [1:0] {IDLE, IREAD, DREAD, WRITE} state_t;
   state_t state, next;
   logic starve, live, done;
   // Reset gates the strobes combinationally so an in-flight access is dropped at once.
   assign live = !RST & ((state == IREAD & iREN) | (state == DREAD & dmissREN) |
                         (state == WRITE & dqueueWEN));
   assign done = live & !ramwait;
   assign next = (state != IDLE) ? ((live & ramwait) ? state : IDLE) :
                 starve              ? IREAD :
                 (dmissREN & wempty) ? DREAD :
                 dqueueWEN           ? WRITE :
                 iREN                ? IREAD : IDLE;
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= next;
   end
   assign ramREN    = live & (state == IREAD | state == DREAD);
   assign ramWEN    = live & (state == WRITE);
   assign ramaddr   = (state == IREAD) ? iaddr :
                      (state == DREAD) ? dmissaddr :
                      (state == WRITE) ? wdaddr : 32'h0;
   assign ramstore  = (!RST & state == WRITE) ? dstore : 32'h0;
   assign iwait     = !(done & state == IREAD);
   assign dmisswait = !(done & state == DREAD);
   assign wqwait    = !(done & state == WRITE);
   assign iload     = (done & state == IREAD) ? ramload : 32'h0;
   assign dload     = (done & state == DREAD) ? ramload : 32'h0;
   always_ff @(posedge CLK) assert (STARVE_LIMIT >= 1 && STARVE_LIMIT <= 15);
`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
   logic [3:0] cnt;
   always_ff @(posedge CLK) begin
      if (RST)                                          cnt <= 4'd0;
      else if (!iREN | (state == IDLE & next == IREAD)) cnt <= 4'd0;
      else if (done & state != IREAD)                   cnt <= cnt + 4'd1;
   end
   assign starve = iREN & (cnt == LIM);
`else
   assign starve = 1'b0;
`endif
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single RAM port between three requesters: instruction-cache fill reads, data-cache miss reads, and the data-cache write queue drain. Sits directly downstream of the write queue, consuming its `dqueueWEN`/`wdaddr`/`dstore` stream and producing the `dwait` that throttles it. A small grant FSM holds one transaction on RAM until RAM completes it, then returns to idle. An optional starvation guard bounds how long instruction fetch can be locked out by data traffic.

## Interface
- `STARVE_LIMIT`, default 4: consecutive completed data grants allowed while `iREN` is pending before the icache is forced to win. Only used with the guard enabled; range 1–15.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iREN`  in  1  icache fill read request; held until `iwait`=0.
- `iaddr`  in  32  icache read address.
- `iwait`  out  1  icache stall; 0 in the cycle its read completes.
- `iload`  out  32  read data to icache; valid when `iwait`=0.
- `dmissREN`  in  1  dcache miss read request; held until `dmisswait`=0.
- `dmissaddr`  in  32  dcache miss address.
- `dmisswait`  out  1  dcache miss stall.
- `dload`  out  32  read data to dcache; valid when `dmisswait`=0.
- `dqueueWEN`  in  1  write queue drain request.
- `wdaddr`  in  32  write queue drain address.
- `dstore`  in  32  write queue drain data.
- `wempty`  in  1  write queue empty flag.
- `wqwait`  out  1  drives the write queue's `dwait`; 0 in the cycle its write completes.
- `ramREN`, `ramWEN`  out  1 each  RAM strobes; never both 1.
- `ramaddr`, `ramstore`  out  32 each  RAM address and write data.
- `ramload`  in  32  RAM read data.
- `ramwait`  in  1  RAM busy; 0 means the current access completes this cycle.

## Operation
- FSM states: IDLE, IREAD, DREAD, WRITE. State register only; RAM outputs decoded combinationally from state and the granted requester's live inputs (requesters hold address/data stable while stalled).
- IDLE: no RAM strobes. Eligible requests: `iREN`; `dqueueWEN`; `dmissREN` only when `wempty`=1, so a miss never reads RAM ahead of a pending writeback.
- Fixed priority in IDLE: DREAD > WRITE > IREAD. Transition to the winner at the next edge; stay IDLE if none.
- IREAD/DREAD: `ramREN`=1, `ramaddr` = that requester's address. WRITE: `ramWEN`=1, `ramaddr`=`wdaddr`, `ramstore`=`dstore`.
- Completion: in a grant state with `ramwait`=0, the granted requester's wait is 0, its load is `ramload` (reads), and the FSM returns to IDLE at the edge.
- Abort: if the granted requester deasserts its request before completion, strobes drop in the same cycle and the FSM returns to IDLE at the edge.
- Waits: each wait output is 1 unless its own transaction is completing this cycle. `iload`/`dload` are 0 unless completing. `ramstore` is 0 outside WRITE.
- Reset: state IDLE, guard counter 0, all waits 1, RAM strobes 0, loads 0. Reset mid-transaction abandons the access immediately.

## Timing
- Request seen in IDLE at cycle 0 → grant state from cycle 1 → earliest completion in cycle 1 (minimum 2-cycle access).
- There is one mandatory IDLE bubble between successive grants. Back-to-back queue drains therefore take at least 2 cycles each.
- Arbitration is decided only in IDLE. A higher-priority request arriving mid-grant waits for completion.
- `dmissREN` with `wempty`=0: the write queue drains first. The miss becomes eligible in the first IDLE cycle after `wempty` rises.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: a 4-bit counter increments on each completed DREAD/WRITE while `iREN`=1. It clears on an IREAD grant or when `iREN`=0. When the counter equals `STARVE_LIMIT`, IREAD takes top priority in IDLE.
- Not defined: no counter; pure fixed priority DREAD > WRITE > IREAD.

## Test plan
- Reset with all requests high, `ramwait`=1 → all waits 1, strobes 0. Release reset → IREAD not selected; WRITE granted in cycle 1 if `dqueueWEN`=1.
- Single icache read, `iaddr`=0x100, `ramwait`=0 → `ramREN`=1 and `ramaddr`=0x100 in cycle 1. `iwait`=0 and `iload`=`ramload` in cycle 1; IDLE in cycle 2.
- `dmissREN`=1 with `wempty`=0 and `dqueueWEN`=1, `wdaddr`=0x200 → WRITE issues first. DREAD is granted only after `wempty`=1.
- `ramwait` held 1 for 5 cycles during WRITE → `wqwait`=1 and `ramWEN` steady throughout. `wqwait` falls in the cycle `ramwait`=0.
- Guard enabled, `STARVE_LIMIT`=4, continuous `dqueueWEN` and `iREN` → IREAD is granted after exactly 4 completed writes. Guard disabled → IREAD is never granted while `dqueueWEN`=1.
- `iREN` dropped in cycle 2 of a stalled IREAD → `ramREN`=0 that cycle; FSM in IDLE next cycle.
